logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range is 1 to 64.
REQ-002 Parameter CNT_W, default 16, width of the delivered-transaction counter; legal range is 2 to 32.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: the upstream operation is valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-007 Port mode, input, 3 bits: operation select.
REQ-008 Port a, input, WIDTH bits: operand A.
REQ-009 Port b, input, WIDTH bits: operand B.
REQ-010 Port out_valid, output, 1 bit: a result is available.
REQ-011 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 Port y, output, WIDTH bits: the result.
REQ-013 Port out_mode, output, 3 bits: the mode that produced y.
REQ-014 Port txn_cnt, output, CNT_W bits: count of delivered results.

Function
REQ-015 Mode encoding SHALL be: 000 AND a&b; 001 OR a|b; 010 NOT ~a (b ignored); 011 NAND; 100 NOR; 101 XOR; 110 XNOR; 111 BUF, which passes b.
REQ-016 Accept SHALL occur when in_valid=1 and in_ready=1 on a rising clk edge; the result and mode are computed from a, b and mode sampled at that edge.
REQ-017 Results SHALL be held in a 2-entry FIFO; y and out_mode SHALL come from the FIFO head.
REQ-018 Latency SHALL be 1 cycle: for an accept at edge N into an empty FIFO, out_valid=1 from edge N until the result is delivered.
REQ-019 in_ready SHALL be 1 exactly when the FIFO occupancy is below 2, derived only from registered state, with no combinational path from out_ready.
REQ-020 Delivery SHALL occur when out_valid=1 and out_ready=1 at an edge; the FIFO then pops its head.
REQ-021 Accept and delivery in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-022 When full (occupancy 2), in_ready=0 and in_valid is ignored; a pop in that cycle frees an entry only from the next cycle.
REQ-023 When empty, out_valid=0 and out_ready is ignored.
REQ-024 y, out_mode and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Results SHALL be delivered strictly in acceptance order; none are dropped or duplicated.
REQ-026 txn_cnt SHALL increment by 1 on each delivery and wrap modulo 2^CNT_W (all-ones plus one gives zero).

Reset
REQ-027 While rst=1 at an edge: occupancy becomes 0, out_valid=0, y=0, out_mode=0 and txn_cnt=0.
REQ-028 While rst=1, in_ready SHALL be 0; in the first cycle after rst falls, in_ready SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard all buffered results, with no delivery in that cycle.

Configuration
REQ-030 Macro LOGIC_UNIT_PIPE_FLAGS_EN: when defined, the block SHALL add output ports out_zero (1 bit, y==0) and out_parity (1 bit, XOR of all y bits).
REQ-031 With LOGIC_UNIT_PIPE_FLAGS_EN defined, the flags SHALL be computed at accept, stored with each FIFO entry, and reset to 0.
REQ-032 With LOGIC_UNIT_PIPE_FLAGS_EN undefined, out_zero and out_parity SHALL not exist and all other behaviour is identical.

Verification
REQ-033 Truth sweep: WIDTH=8, out_ready=1, a=0xF0, b=0x3C, modes 0 to 7 -> y = 30, FC, 0F, CF, 03, CC, 33, 3C one cycle after each accept.
REQ-034 Backpressure: out_ready=0, three back-to-back ops -> in_ready=0 after 2 accepts; the third is held. Then out_ready=1 -> all three are delivered in order, and txn_cnt=3.
REQ-035 Simultaneous event: occupancy 1, accept and delivery in one cycle -> occupancy stays 1, in_ready stays 1, no reordering.
REQ-036 Mid-run reset: occupancy 2, rst pulsed 1 cycle -> out_valid=0, txn_cnt=0, y=0, and in_ready=1 on the cycle after reset.
REQ-037 Wrap: CNT_W=4, 17 deliveries -> txn_cnt reads 15 after 15, 0 after 16, and 1 after 17.
REQ-038 Flags, with LOGIC_UNIT_PIPE_FLAGS_EN: XOR a=0x55, b=0x55 -> y=0x00, out_zero=1, out_parity=0. BUF b=0x07 -> out_zero=0, out_parity=1.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit feeding a 2-entry result FIFO with valid/ready on both sides.
// Optional flag outputs (out_zero, out_parity) are enabled by LOGIC_UNIT_PIPE_FLAGS_EN.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       out_mode,
  output logic [CNT_W-1:0] txn_cnt
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and in_ready depends only on stored occupancy (and rst).

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_NOT  = 3'd2;
  localparam logic [2:0] MODE_NAND = 3'd3;
  localparam logic [2:0] MODE_NOR  = 3'd4;
  localparam logic [2:0] MODE_XOR  = 3'd5;
  localparam logic [2:0] MODE_XNOR = 3'd6;

  logic [WIDTH-1:0] r_y_mem    [2];
  logic [2:0]       r_mode_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_txn_cnt;

  logic [WIDTH-1:0] w_result;
  logic             w_push;
  logic             w_pop;
  logic             w_out_valid;

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  logic [1:0] r_zero_mem;
  logic [1:0] r_par_mem;
`endif

  always_comb begin
    w_result = '0;
    case (mode)
      MODE_AND:  w_result = a & b;
      MODE_OR:   w_result = a | b;
      MODE_NOT:  w_result = ~a;
      MODE_NAND: w_result = ~(a & b);
      MODE_NOR:  w_result = ~(a | b);
      MODE_XOR:  w_result = a ^ b;
      MODE_XNOR: w_result = ~(a ^ b);
      default:   w_result = b;
    endcase
  end

  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = w_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_mem[0]    <= '0;
      r_y_mem[1]    <= '0;
      r_mode_mem[0] <= '0;
      r_mode_mem[1] <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_txn_cnt     <= '0;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
      r_zero_mem    <= 2'b00;
      r_par_mem     <= 2'b00;
`endif
    end else begin
      if (w_push) begin
        r_y_mem[r_wr_ptr]    <= w_result;
        r_mode_mem[r_wr_ptr] <= mode;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        r_zero_mem[r_wr_ptr] <= (w_result == '0);
        r_par_mem[r_wr_ptr]  <= ^w_result;
`endif
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr  <= ~r_rd_ptr;
        r_txn_cnt <= r_txn_cnt + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // rst gates in_ready so nothing is offered as accepted while reset is held.
  assign in_ready  = ~rst & (r_count != 2'd2);
  assign out_valid = w_out_valid;
  assign y         = w_out_valid ? r_y_mem[r_rd_ptr] : '0;
  assign out_mode  = w_out_valid ? r_mode_mem[r_rd_ptr] : 3'd0;
  assign txn_cnt   = r_txn_cnt;

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  assign out_zero   = w_out_valid & r_zero_mem[r_rd_ptr];
  assign out_parity = w_out_valid & r_par_mem[r_rd_ptr];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: truth sweep, backpressure, simultaneous push/pop,
// mid-run reset, counter wrap (CNT_W=4) and, with LOGIC_UNIT_PIPE_FLAGS_EN, the flags.
module tb_logic_unit_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [2:0]       out_mode;
  logic [CNT_W-1:0] txn_cnt;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  logic             out_zero;
  logic             out_parity;
`endif

  int n_checks;
  int n_errors;

  logic [WIDTH-1:0] sweep_exp [8];

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_mode  (out_mode),
    .txn_cnt   (txn_cnt)
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_parity(out_parity)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge, then settle 1 time unit for sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic [2:0] m,
                          input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    in_valid = v;
    mode     = m;
    a        = av;
    b        = bv;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 3'd0;
    a         = '0;
    b         = '0;
    sweep_exp[0] = 8'h30; sweep_exp[1] = 8'hFC; sweep_exp[2] = 8'h0F; sweep_exp[3] = 8'hCF;
    sweep_exp[4] = 8'h03; sweep_exp[5] = 8'hCC; sweep_exp[6] = 8'h33; sweep_exp[7] = 8'h3C;

    // reset state
    step();
    step();
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y",         64'(y),         64'd0);
    check("rst_out_mode",  64'(out_mode),  64'd0);
    check("rst_txn",       64'(txn_cnt),   64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // truth sweep, back-to-back with out_ready=1
    out_ready = 1'b1;
    for (int m = 0; m < 8; m++) begin
      drive_op(1'b1, 3'(m), 8'hF0, 8'h3C);
      step();
      check($sformatf("sweep_valid_m%0d", m), 64'(out_valid), 64'd1);
      check($sformatf("sweep_y_m%0d", m),     64'(y),         64'(sweep_exp[m]));
      check($sformatf("sweep_mode_m%0d", m),  64'(out_mode),  64'(m));
    end
    in_valid = 1'b0;
    step();
    check("sweep_drain_valid", 64'(out_valid), 64'd0);
    check("sweep_txn",         64'(txn_cnt),   64'd8);

    // backpressure: three ops with out_ready=0
    do_reset();
    out_ready = 1'b0;
    drive_op(1'b1, 3'd0, 8'hAA, 8'h0F);   // AND -> 0A
    step();
    check("bp_ready_1", 64'(in_ready), 64'd1);
    check("bp_y_1",     64'(y),        64'h0A);
    drive_op(1'b1, 3'd1, 8'hA0, 8'h05);   // OR -> A5
    step();
    check("bp_ready_2", 64'(in_ready), 64'd0);
    drive_op(1'b1, 3'd5, 8'hFF, 8'h0F);   // XOR -> F0, held off
    step();
    check("bp_ready_held", 64'(in_ready),  64'd0);
    check("bp_y_stable",   64'(y),         64'h0A);
    check("bp_mode_stable", 64'(out_mode), 64'd0);
    check("bp_txn_0",      64'(txn_cnt),   64'd0);
    out_ready = 1'b1;
    step();
    check("bp_pop1_y",     64'(y),        64'hA5);
    check("bp_pop1_mode",  64'(out_mode), 64'd1);
    check("bp_pop1_txn",   64'(txn_cnt),  64'd1);
    check("bp_pop1_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_pop2_y",    64'(y),        64'hF0);
    check("bp_pop2_mode", 64'(out_mode), 64'd5);
    check("bp_pop2_txn",  64'(txn_cnt),  64'd2);
    step();
    check("bp_done_valid", 64'(out_valid), 64'd0);
    check("bp_done_txn",   64'(txn_cnt),   64'd3);

    // simultaneous accept and delivery at occupancy 1
    do_reset();
    out_ready = 1'b0;
    drive_op(1'b1, 3'd2, 8'h12, 8'h00);   // NOT -> ED
    step();
    check("sim_head_y", 64'(y), 64'hED);
    drive_op(1'b1, 3'd4, 8'h01, 8'h02);   // NOR -> FC
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("sim_ready", 64'(in_ready),  64'd1);
    check("sim_valid", 64'(out_valid), 64'd1);
    check("sim_y",     64'(y),         64'hFC);
    check("sim_mode",  64'(out_mode),  64'd4);
    check("sim_txn",   64'(txn_cnt),   64'd1);
    step();
    check("sim_drain_valid", 64'(out_valid), 64'd0);
    check("sim_drain_txn",   64'(txn_cnt),   64'd2);

    // mid-run reset with a full FIFO
    out_ready = 1'b0;
    drive_op(1'b1, 3'd7, 8'h00, 8'h5A);
    step();
    drive_op(1'b1, 3'd7, 8'h00, 8'hA5);
    step();
    check("mr_full_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    step();
    check("mr_valid",    64'(out_valid), 64'd0);
    check("mr_y",        64'(y),         64'd0);
    check("mr_txn",      64'(txn_cnt),   64'd0);
    check("mr_ready_in", 64'(in_ready),  64'd0);
    rst = 1'b0;
    #1;
    check("mr_ready_after", 64'(in_ready), 64'd1);
    step();
    check("mr_no_stale", 64'(out_valid), 64'd0);
    check("mr_txn_hold", 64'(txn_cnt),   64'd0);

    // counter wrap: 17 BUF ops streamed with out_ready=1
    do_reset();
    out_ready = 1'b1;
    for (int j = 1; j <= 18; j++) begin
      if (j <= 17) drive_op(1'b1, 3'd7, 8'h00, 8'(j));
      else         in_valid = 1'b0;
      step();
      if (j <= 17) check($sformatf("wrap_y_%0d", j), 64'(y), 64'(j));
      if (j == 16) check("wrap_txn_15", 64'(txn_cnt), 64'd15);
      if (j == 17) check("wrap_txn_0",  64'(txn_cnt), 64'd0);
      if (j == 18) check("wrap_txn_1",  64'(txn_cnt), 64'd1);
    end

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    do_reset();
    check("flag_rst_zero",   64'(out_zero),   64'd0);
    check("flag_rst_parity", 64'(out_parity), 64'd0);
    out_ready = 1'b0;
    drive_op(1'b1, 3'd5, 8'h55, 8'h55);   // XOR -> 00
    step();
    drive_op(1'b1, 3'd7, 8'h00, 8'h07);   // BUF -> 07
    step();
    in_valid = 1'b0;
    check("flag_xor_y",      64'(y),          64'h00);
    check("flag_xor_zero",   64'(out_zero),   64'd1);
    check("flag_xor_parity", 64'(out_parity), 64'd0);
    out_ready = 1'b1;
    step();
    check("flag_buf_y",      64'(y),          64'h07);
    check("flag_buf_zero",   64'(out_zero),   64'd0);
    check("flag_buf_parity", 64'(out_parity), 64'd1);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
